// File: rtl/period_meter.sv
// Period / high-time meter: measures rise-to-rise interval of an asynchronous input in clk cycles.
// Optional high-time counter is built only when PERIOD_METER_HIGH_TIME_EN is defined.
module period_meter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             meas_en,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE, HOLD} state_t;

  localparam logic [WIDTH-1:0] TMO_LAST = WIDTH'(TIMEOUT - 1);

  state_t           state, state_d;
  logic             sync_meta, sync_q, edge_q, rise;
  logic [WIDTH-1:0] tmo_cnt, period_cnt;
  logic             tmo_hit;
  logic             clr_tmo, start, step, done, expire;

  // Fixed three-flop path: every edge sees the same latency, so intervals are exact.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      sync_meta <= sig;
      sync_q    <= sync_meta;
      edge_q    <= sync_q;
    end
  end

  assign rise    = sync_q & ~edge_q;
  assign tmo_hit = (tmo_cnt == TMO_LAST);
  assign valid   = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    clr_tmo = 1'b0;
    start   = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (meas_en) begin
          state_d = WAIT_RISE;
          clr_tmo = 1'b1;
        end
      end
      WAIT_RISE: begin
        if (!meas_en) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = MEASURE;
          start   = 1'b1;
        end else if (tmo_hit) begin
          state_d = HOLD;
          expire  = 1'b1;
        end
      end
      MEASURE: begin
        // A rise on the expiry cycle wins over the timeout.
        if (!meas_en) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = HOLD;
          done    = 1'b1;
        end else if (tmo_hit) begin
          state_d = HOLD;
          expire  = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      HOLD: begin
        if (ready) begin
          state_d = meas_en ? WAIT_RISE : IDLE;
          clr_tmo = 1'b1;
        end
      end
    endcase
  end

  // The timeout counter restarts on entry to WAIT_RISE and to MEASURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt    <= '0;
      period_cnt <= '0;
      period     <= '0;
      timeout    <= 1'b0;
    end else begin
      if (clr_tmo || start)
        tmo_cnt <= '0;
      else if (state == WAIT_RISE || state == MEASURE)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (start)
        period_cnt <= WIDTH'(1);
      else if (step)
        period_cnt <= period_cnt + 1'b1;

      if (done) begin
        period  <= period_cnt;
        timeout <= 1'b0;
      end else if (expire) begin
        period  <= '0;
        timeout <= 1'b1;
      end
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [WIDTH-1:0] high_cnt, high_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      high_cnt <= '0;
      high_q   <= '0;
    end else begin
      if (start)
        high_cnt <= WIDTH'(1);
      else if (step && sync_q)
        high_cnt <= high_cnt + 1'b1;

      if (done)
        high_q <= high_cnt;
      else if (expire)
        high_q <= '0;
    end
  end

  assign high_time = high_q;
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus pushes expected results derived from the waveform
// shape; an independent monitor pops and compares whenever valid is presented.
module tb_period_meter;

  localparam int W   = 16;
  localparam int TMO = 100;
`ifdef PERIOD_METER_HIGH_TIME_EN
  localparam bit HT_EN = 1'b1;
`else
  localparam bit HT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, sig, meas_en, ready;
  logic         valid, timeout;
  logic [W-1:0] period, high_time;

  always #5 clk = ~clk;

  period_meter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .meas_en   (meas_en),
    .ready     (ready),
    .valid     (valid),
    .period    (period),
    .high_time (high_time),
    .timeout   (timeout)
  );

  typedef struct {
    int period;
    int high;
    bit tmo;
  } result_t;

  result_t sb[$];
  int      checks       = 0;
  int      errors       = 0;
  int      forced_delay = -1;
  bit      hold_ready   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a wave with rise-to-rise n and high h. The second rise is reached only if the
  // measurement window (TMO cycles after entering MEASURE, i.e. up to n == TMO) covers it.
  function automatic result_t model(input int n, input int h);
    result_t r;
    if (n > TMO) begin
      r.period = 0; r.high = 0; r.tmo = 1'b1;
    end else begin
      r.period = n; r.high = HT_EN ? h : 0; r.tmo = 1'b0;
    end
    return r;
  endfunction

  // Monitor: pops an expectation at each presented result, holds ready low for a random
  // (or forced) number of cycles while checking the outputs stay put, then accepts.
  initial begin
    result_t exp;
    logic [W-1:0] p0, h0;
    logic         t0;
    int           delay, k;
    bit           stable;
    ready = 1'b0;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(valid), 32'd0);
        end else begin
          exp = sb.pop_front();
          check("period", 32'(period), 32'(exp.period));
          check("high_time", 32'(high_time), 32'(exp.high));
          check("timeout", 32'(timeout), 32'(exp.tmo));
          p0 = period; h0 = high_time; t0 = timeout;
          delay  = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 5));
          k      = 0;
          stable = 1'b1;
          while (valid && (hold_ready || k < delay)) begin
            if (period !== p0 || high_time !== h0 || timeout !== t0) stable = 1'b0;
            @(negedge clk);
            k++;
          end
          check("hold_stable", 32'(stable), 32'd1);
          if (valid) begin
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            check("valid_drop_after_accept", 32'(valid), 32'd0);
          end
        end
      end
    end
  end

  task automatic wait_valid(input string name, input int limit);
    for (int i = 0; i < limit && !valid; i++) @(negedge clk);
    check(name, 32'(valid), 32'd1);
  endtask

  task automatic wait_released(input int limit);
    for (int i = 0; i < limit && valid; i++) @(negedge clk);
    check("released", 32'(valid), 32'd0);
  endtask

  // Drives one high phase of h cycles, n-h low cycles, then a second rise held until valid.
  task automatic drive_wave(input int n, input int h);
    sb.push_back(model(n, h));
    @(negedge clk);
    meas_en = 1'b1;
    sig     = 1'b1;
    repeat (h) @(negedge clk);
    sig = 1'b0;
    repeat (n - h) @(negedge clk);
    sig = 1'b1;
    wait_valid("result_presented", 2 * TMO + 20);
  endtask

  task automatic run_wave(input int n, input int h);
    drive_wave(n, h);
    meas_en = 1'b0;
    sig     = 1'b0;
    wait_released(200);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_high_time"}, 32'(high_time), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int n, h, cyc;
    bit saw;
    result_t r;
    rst = 1'b1; sig = 1'b0; meas_en = 1'b0;
    repeat (3) @(negedge clk);
    check_zeroed("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_wave(10, 5);
    for (int i = 0; i < 12; i++) begin
      n = int'($urandom_range(2, 40));
      h = int'($urandom_range(1, n - 1));
      run_wave(n, h);
    end

    // Second rise exactly on the expiry cycle, then one cycle too late.
    run_wave(TMO, 37);
    run_wave(TMO + 1, 50);
    run_wave(2, 1);

    // Consumer stalls for 50 cycles, then a fresh measurement.
    forced_delay = 50;
    run_wave(10, 5);
    forced_delay = -1;
    run_wave(10, 5);

    // No rise at all: WAIT_RISE is entered on the first posedge after meas_en, and the
    // result appears TMO cycles later, so TMO+1 negedges after driving meas_en.
    r.period = 0; r.high = 0; r.tmo = 1'b1;
    sb.push_back(r);
    @(negedge clk);
    meas_en = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!valid && cyc < 3 * TMO);
    check("wait_rise_timeout_latency", 32'(cyc), 32'(TMO + 1));
    meas_en = 1'b0;
    wait_released(200);
    repeat (4) @(negedge clk);

    // Abort mid-measurement: no result may ever appear.
    @(negedge clk);
    meas_en = 1'b1;
    sig     = 1'b1;
    repeat (8) @(negedge clk);
    meas_en = 1'b0;
    saw = 1'b0;
    repeat (2 * TMO) begin
      @(negedge clk);
      if (valid) saw = 1'b1;
    end
    check("abort_no_valid", 32'(saw), 32'd0);
    sig = 1'b0;
    repeat (4) @(negedge clk);
    run_wave(10, 5);

    // Reset during MEASURE; the previous result (period 10) must be wiped.
    @(negedge clk);
    meas_en = 1'b1;
    sig     = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1; meas_en = 1'b0; sig = 1'b0;
    @(negedge clk);
    check_zeroed("rst_measure");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during HOLD while the consumer withholds ready, with meas_en dropped.
    hold_ready = 1'b1;
    drive_wave(12, 4);
    meas_en = 1'b0;
    sig     = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_kept_without_en", 32'(valid), 32'd1);
    check("hold_period", 32'(period), 32'd12);
    rst = 1'b1;
    @(negedge clk);
    check_zeroed("rst_hold");
    rst = 1'b0;
    hold_ready = 1'b0;
    repeat (4) @(negedge clk);
    run_wave(10, 5);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the width of the measurement counters and result ports.
REQ-002 Parameter TIMEOUT, default 100000000, SHALL set the maximum cycles waited for any single rising edge (2 s at 50 MHz).
REQ-003 The parameters SHALL satisfy 2 <= TIMEOUT <= 2^WIDTH-1; a violating value is unsupported.
REQ-004 clk  input  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 sig  input  1  SHALL be the waveform to measure, asynchronous to clk.
REQ-007 meas_en  input  1  SHALL enable measurement when high.
REQ-008 ready  input  1  SHALL be the consumer acceptance of the result.
REQ-009 valid  output  1  SHALL flag that the result outputs are held for the consumer.
REQ-010 period  output  WIDTH  SHALL carry the measured period in clk cycles.
REQ-011 high_time  output  WIDTH  SHALL carry the measured high time in clk cycles.
REQ-012 timeout  output  1  SHALL flag that the result ended by timeout rather than by an edge.

Function
REQ-013 sig SHALL pass through a two-flop synchronizer, then one edge register; a rising edge is sync_q=1 with edge_q=0.
REQ-014 Edge detection latency SHALL be 3 clk cycles and identical for every edge, so measured intervals are exact.
REQ-015 The FSM SHALL have states IDLE, WAIT_RISE, MEASURE and HOLD.
REQ-016 IDLE: meas_en=1 SHALL transition to WAIT_RISE and clear the timeout counter.
REQ-017 WAIT_RISE: a detected rise SHALL transition to MEASURE with period count=1 and high count=1.
REQ-018 MEASURE: each cycle without a rise SHALL increment the period count, and SHALL increment the high count when sync_q=1.
REQ-019 MEASURE: a detected rise SHALL latch the period and high counts into period/high_time, clear timeout, and transition to HOLD.
REQ-020 Consequently, a square wave with an N-cycle period and H high cycles SHALL yield period=N and high_time=H.
REQ-021 In WAIT_RISE and in MEASURE, the timeout counter SHALL reach TIMEOUT cycles, counted from state entry, without a rise; the FSM SHALL then enter HOLD with period=0, high_time=0 and timeout=1.
REQ-022 In HOLD, valid=1, and period/high_time/timeout SHALL be stable; sig edges SHALL be ignored.
REQ-023 In HOLD, ready=1 SHALL complete the transfer in that cycle; the next state SHALL be WAIT_RISE if meas_en=1, else IDLE.
REQ-024 A rise and a timeout in the same cycle SHALL resolve as the rise.
REQ-025 meas_en=0 in WAIT_RISE or MEASURE SHALL abort to IDLE on the next cycle without asserting valid.
REQ-026 meas_en=0 in HOLD SHALL NOT drop valid; the held result SHALL remain until accepted.
REQ-027 Counters SHALL never wrap, because the timeout fires at or below 2^WIDTH-1.

Reset
REQ-028 rst=1 SHALL force IDLE, valid=0, period=0, high_time=0, timeout=0, all counters=0, and synchronizer/edge flops=0, from any state.
REQ-029 A rise detected in the first cycles after reset, caused by the zeroed synchronizer, SHALL be treated as a normal edge.

Configuration
REQ-030 Macro PERIOD_METER_HIGH_TIME_EN, when defined, SHALL include the high-time counter and drive high_time per REQ-018/019.
REQ-031 Without PERIOD_METER_HIGH_TIME_EN, the high counter SHALL be omitted, high_time SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-032 sig from a 10-cycle square wave (5 high), meas_en=1, ready=1 -> first valid result period=10, high_time=5 (0 if macro undefined), timeout=0.
REQ-033 TIMEOUT=100, sig held 0, meas_en=1 -> valid with timeout=1, period=0, 100 cycles after WAIT_RISE entry.
REQ-034 10-cycle wave, ready=0 for 50 cycles after valid -> outputs stable throughout; on ready=1, valid drops and a new measurement yields period=10.
REQ-035 meas_en dropped mid-MEASURE -> IDLE next cycle, valid never asserts; re-enable -> correct period=10.
REQ-036 rst pulsed during MEASURE and during HOLD -> all outputs 0 next cycle, FSM in IDLE.
REQ-037 Rise arriving on the exact cycle the timeout count expires -> timeout=0 and period latched normally.
